// File: rtl/cpu_sequencer_if.sv
// Instruction-fetch channel between cpu_sequencer (master) and instruction memory (slave).
// imem_addr is held stable while imem_req is high; imem_data is valid in the imem_ack cycle.
interface cpu_sequencer_if;
   logic        imem_req;
   logic [11:0] imem_addr;
   logic        imem_ack;
   logic [18:0] imem_data;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_data);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_data);
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: fetch/decode/exec/mem/wb FSM, PC, IR, Z/C flags, call stack.
// Optional macro CALLSTACK_GUARD_EN: stack overflow/underflow raises sticky fault and halts.
module cpu_sequencer #(
   parameter int          STACK_DEPTH = 8,
   parameter logic [11:0] PC_RESET    = 12'h000
) (
   input  logic                  clk,
   input  logic                  rst,
   cpu_sequencer_if.master       imem,
   output logic [18:0]           ir,
   output logic [11:0]           pc,
   output logic                  reg_we,
   output logic                  ra2_sel,
   output logic [1:0]            wb_sel,
   output logic                  dmem_re,
   output logic                  dmem_we,
   input  logic                  alu_cout,
   input  logic                  alu_zero,
   input  logic                  sh_cout,
   input  logic                  sh_zero,
   output logic                  flag_z,
   output logic                  flag_c,
   output logic                  retired,
   output logic                  fault
);

   localparam int AW = $clog2(STACK_DEPTH);
`ifdef CALLSTACK_GUARD_EN
   // One extra bit so a completely full stack (sp == STACK_DEPTH) is representable.
   localparam int SPW = AW + 1;
`else
   localparam int SPW = AW;
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t           state, state_next;
   logic [SPW-1:0]   sp, sp_inc, sp_dec;
   logic [11:0]      stack [STACK_DEPTH];
   logic [11:0]      pc_next;
   logic             fetch_req, ir_load, pc_we, push, pop, flag_we, fault_set;
   logic             z_next, c_next;
   logic             is_alu, is_mem, is_br, is_sh, is_ret, is_call;
   logic             br_taken, stack_fault;

   assign is_alu  = ~ir[18];
   assign is_mem  = (ir[18:16] == 3'b100);
   assign is_br   = (ir[18:16] == 3'b101);
   assign is_sh   = (ir[18:16] == 3'b110);
   assign is_ret  = (ir[18:16] == 3'b111) &  ir[15];
   assign is_call = (ir[18:16] == 3'b111) & ~ir[15] & ir[14];

   assign sp_inc = sp + SPW'(1);
   assign sp_dec = sp - SPW'(1);

`ifdef CALLSTACK_GUARD_EN
   assign stack_fault = (is_call && (sp == SPW'(STACK_DEPTH))) || (is_ret && (sp == '0));
`else
   assign stack_fault = 1'b0;
`endif

   always_comb begin
      case (ir[15:14])
         2'b00:   br_taken =  flag_z;
         2'b01:   br_taken = ~flag_z;
         2'b10:   br_taken =  flag_c;
         default: br_taken = ~flag_c;
      endcase
   end

   assign imem.imem_req  = fetch_req;
   assign imem.imem_addr = pc;

   always_comb begin
      state_next = state;
      fetch_req  = 1'b0;
      reg_we     = 1'b0;
      ra2_sel    = 1'b0;
      wb_sel     = 2'b00;
      dmem_re    = 1'b0;
      dmem_we    = 1'b0;
      retired    = 1'b0;
      ir_load    = 1'b0;
      pc_we      = 1'b0;
      pc_next    = pc;
      push       = 1'b0;
      pop        = 1'b0;
      flag_we    = 1'b0;
      z_next     = flag_z;
      c_next     = flag_c;
      fault_set  = 1'b0;
      case (state)
         S_IDLE: state_next = S_FETCH;
         S_FETCH: begin
            fetch_req = 1'b1;
            if (imem.imem_ack) begin
               ir_load    = 1'b1;
               pc_we      = 1'b1;
               pc_next    = pc + 12'd1;
               state_next = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_alu || is_sh) begin
               state_next = S_EXEC;
            end else if (is_mem) begin
               state_next = S_MEM;
            end else if (is_br) begin
               retired    = 1'b1;
               state_next = S_FETCH;
               if (br_taken) begin
                  pc_we   = 1'b1;
                  pc_next = pc + {4'b0, ir[7:0]};
               end
            end else if (stack_fault) begin
               fault_set  = 1'b1;
               state_next = S_HALT;
            end else if (is_ret) begin
               pop        = 1'b1;
               pc_we      = 1'b1;
               pc_next    = stack[sp_dec[AW-1:0]];
               retired    = 1'b1;
               state_next = S_FETCH;
            end else begin
               // pc already points past the call, so it is the return address.
               push       = is_call;
               pc_we      = 1'b1;
               pc_next    = ir[11:0];
               retired    = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_EXEC: begin
            retired    = 1'b1;
            flag_we    = 1'b1;
            state_next = S_FETCH;
            if (ir == '0) begin
               z_next = 1'b0;
               c_next = 1'b0;
            end else if (is_sh) begin
               reg_we = 1'b1;
               wb_sel = 2'b10;
               z_next = sh_zero;
               c_next = sh_cout;
            end else begin
               reg_we = 1'b1;
               z_next = alu_zero;
               c_next = alu_cout;
            end
         end
         S_MEM: begin
            if (ir[14]) begin
               ra2_sel    = 1'b1;
               dmem_we    = 1'b1;
               retired    = 1'b1;
               state_next = S_FETCH;
            end else begin
               dmem_re    = 1'b1;
               state_next = S_WB;
            end
         end
         S_WB: begin
            wb_sel     = 2'b01;
            reg_we     = 1'b1;
            retired    = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT: state_next = S_HALT;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         pc     <= PC_RESET;
         ir     <= '0;
         sp     <= '0;
         flag_z <= 1'b0;
         flag_c <= 1'b0;
         fault  <= 1'b0;
      end else begin
         state <= state_next;
         if (ir_load) ir <= imem.imem_data;
         if (pc_we)   pc <= pc_next;
         if (push)     sp <= sp_inc;
         else if (pop) sp <= sp_dec;
         if (flag_we) begin
            flag_z <= z_next;
            flag_c <= c_next;
         end
         if (fault_set) fault <= 1'b1;
      end
   end

   // Stack storage is plain data; reset discards it by clearing sp only.
   always_ff @(posedge clk) begin
      if (push) stack[sp[AW-1:0]] <= pc;
   end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: an instruction-level model predicts each instruction's
// fetch address, latency, strobes and flags; a negedge monitor compares on every retired pulse.
module tb_cpu_sequencer;

   localparam int          DEPTH  = 8;
   localparam logic [11:0] PC_RST = 12'h000;

   typedef struct {
      logic [11:0] addr;
      int          lat;
      int          nreg;
      logic [1:0]  wbs;
      int          nre;
      int          nwe;
      bit          ldm;
      bit          z;
      bit          c;
      bit          retires;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [18:0] ir;
   logic [11:0] pc;
   logic        reg_we, ra2_sel, dmem_re, dmem_we, retired, fault, flag_z, flag_c;
   logic [1:0]  wb_sel;
   logic        alu_cout, alu_zero, sh_cout, sh_zero;

   cpu_sequencer_if bus ();

   cpu_sequencer #(.STACK_DEPTH(DEPTH), .PC_RESET(PC_RST)) dut (
      .clk(clk), .rst(rst), .imem(bus), .ir(ir), .pc(pc),
      .reg_we(reg_we), .ra2_sel(ra2_sel), .wb_sel(wb_sel),
      .dmem_re(dmem_re), .dmem_we(dmem_we),
      .alu_cout(alu_cout), .alu_zero(alu_zero), .sh_cout(sh_cout), .sh_zero(sh_zero),
      .flag_z(flag_z), .flag_c(flag_c), .retired(retired), .fault(fault)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_fail = 0;
   bit          abort = 0;
   exp_t        sb[$];

   // Architectural model state
   logic [11:0] m_pc;
   bit          m_z, m_c, m_fault;
   logic [11:0] m_stk[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = PC_RST; m_z = 0; m_c = 0; m_fault = 0;
      m_stk.delete();
   endtask

   // fl = {alu_zero, alu_cout, sh_zero, sh_cout} presented with this instruction
   task automatic model(input logic [18:0] w, input int waits, input logic [3:0] fl, output exp_t r);
      int lat;
      r.addr = m_pc; r.retires = 1; r.nreg = 0; r.wbs = 2'b00;
      r.nre = 0; r.nwe = 0; r.ldm = 0;
      m_pc = m_pc + 12'd1;
      case (w[18:16])
         3'b100: begin
            if (w[14]) begin lat = 3; r.nwe = 1; end
            else begin lat = 4; r.nre = 1; r.nreg = 1; r.wbs = 2'b01; r.ldm = 1; end
         end
         3'b101: begin
            bit taken;
            lat = 2;
            case (w[15:14])
               2'b00: taken = m_z;
               2'b01: taken = !m_z;
               2'b10: taken = m_c;
               default: taken = !m_c;
            endcase
            if (taken) m_pc = m_pc + {4'b0, w[7:0]};
         end
         3'b110: begin lat = 3; r.nreg = 1; r.wbs = 2'b10; m_z = fl[1]; m_c = fl[0]; end
         3'b111: begin
            lat = 2;
            if (w[15]) begin
               if (m_stk.size() == 0) begin
`ifdef CALLSTACK_GUARD_EN
                  m_fault = 1; r.retires = 0;
`endif
               end else begin
                  m_pc = m_stk.pop_back();
               end
            end else begin
               if (w[14]) begin
                  if (m_stk.size() == DEPTH) begin
`ifdef CALLSTACK_GUARD_EN
                     m_fault = 1; r.retires = 0;
`else
                     void'(m_stk.pop_front());
                     m_stk.push_back(m_pc);
`endif
                  end else begin
                     m_stk.push_back(m_pc);
                  end
               end
               if (!m_fault) m_pc = w[11:0];
            end
         end
         default: begin
            lat = 3;
            if (w == '0) begin m_z = 0; m_c = 0; end
            else begin r.nreg = 1; m_z = fl[3]; m_c = fl[2]; end
         end
      endcase
      r.lat = lat + waits;
      r.z = m_z;
      r.c = m_c;
   endtask

   // Must be called at a negedge; returns at the negedge after the ack edge.
   task automatic issue(input logic [18:0] w, input int waits, input logic [3:0] fl);
      exp_t r;
      int   t;
      if (abort) return;
      model(w, waits, fl, r);
      if (r.retires) sb.push_back(r);
      t = 0;
      while (!bus.imem_req && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!bus.imem_req) begin
         chk("req_timeout", 0, 1);
         abort = 1;
         return;
      end
      repeat (waits) begin
         bus.imem_data = 19'($urandom);
         @(negedge clk);
      end
      bus.imem_ack  = 1'b1;
      bus.imem_data = w;
      {alu_zero, alu_cout, sh_zero, sh_cout} = fl;
      @(negedge clk);
      bus.imem_ack  = 1'b0;
      bus.imem_data = 19'($urandom);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #1 rst = 1'b1;
      sb.delete();
      model_reset();
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
   endtask

   function automatic logic [18:0] gen_word();
      logic [18:0] w;
      int          k;
      w = 19'($urandom);
      k = $urandom_range(0, 9);
      case (k)
         0, 1, 2: w[18] = 1'b0;
         3: w[18:16] = 3'b100;
         4: w[18:16] = 3'b101;
         5: w[18:16] = 3'b110;
         6: begin w[18:15] = 4'b1110; w[14] = 1'b0; end
         7: begin w[18:15] = 4'b1110; w[14] = (m_stk.size() < DEPTH); end
         8: if (m_stk.size() > 0) w[18:15] = 4'b1111; else w[18] = 1'b0;
         default: w = '0;
      endcase
      return w;
   endfunction

   function automatic logic [18:0] call_w(input logic [11:0] tgt);
      return {3'b111, 1'b0, 1'b1, 2'b00, tgt};
   endfunction

   function automatic logic [18:0] jmp_w(input logic [11:0] tgt);
      return {3'b111, 1'b0, 1'b0, 2'b00, tgt};
   endfunction

   localparam logic [18:0] RET_W = {3'b111, 1'b1, 15'd0};
   localparam logic [18:0] ALU_W = 19'h04A5C;

   // Monitor: collects per-instruction observations and checks them against the scoreboard.
   bit          busy = 0, pend = 0, stable;
   bit          pz, pc_flag;
   int          cyc, nreg, nre, nwe, nra2, re_cyc, we_cyc;
   logic [1:0]  wbs_seen;
   logic [11:0] a0;

   initial begin
      exp_t r;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 0;
            pend = 0;
         end else begin
            if (pend) begin
               chk("flag_z", int'(flag_z), int'(pz));
               chk("flag_c", int'(flag_c), int'(pc_flag));
               pend = 0;
            end
            if (!busy && bus.imem_req) begin
               busy = 1; cyc = 0; a0 = bus.imem_addr; stable = 1;
               nreg = 0; nre = 0; nwe = 0; nra2 = 0; re_cyc = 0; we_cyc = 0; wbs_seen = 2'b00;
            end
            if (busy) begin
               cyc++;
               if (bus.imem_req && bus.imem_addr != a0) stable = 0;
               if (reg_we)  begin nreg++; wbs_seen = wb_sel; we_cyc = cyc; end
               if (dmem_re) begin nre++; re_cyc = cyc; end
               if (dmem_we) nwe++;
               if (ra2_sel) nra2++;
               if (retired) begin
                  if (sb.size() == 0) begin
                     chk("sb_empty_at_retire", 0, 1);
                  end else begin
                     r = sb.pop_front();
                     chk("fetch_addr", int'(a0), int'(r.addr));
                     chk("addr_stable", int'(stable), 1);
                     chk("latency", cyc, r.lat);
                     chk("reg_we_count", nreg, r.nreg);
                     if (r.nreg > 0) chk("wb_sel", int'(wbs_seen), int'(r.wbs));
                     chk("dmem_re_count", nre, r.nre);
                     chk("dmem_we_count", nwe, r.nwe);
                     chk("ra2_sel_count", nra2, r.nwe);
                     if (r.ldm) chk("ldm_re_to_we", we_cyc - re_cyc, 1);
                     chk("fault_clear", int'(fault), 0);
                     pz = r.z;
                     pc_flag = r.c;
                     pend = 1;
                  end
                  busy = 0;
               end
            end else if (retired) begin
               chk("spurious_retire", 1, 0);
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      bus.imem_ack = 1'b0;
      bus.imem_data = '0;
      {alu_zero, alu_cout, sh_zero, sh_cout} = 4'b0000;
      model_reset();
      repeat (2) @(negedge clk);
      chk("rst_imem_req", int'(bus.imem_req), 0);
      chk("rst_reg_we", int'(reg_we), 0);
      chk("rst_dmem_re", int'(dmem_re), 0);
      chk("rst_dmem_we", int'(dmem_we), 0);
      chk("rst_retired", int'(retired), 0);
      chk("rst_ra2_sel", int'(ra2_sel), 0);
      chk("rst_wb_sel", int'(wb_sel), 0);
      chk("rst_pc", int'(pc), int'(PC_RST));
      chk("rst_ir", int'(ir), 0);
      chk("rst_flags", int'({flag_z, flag_c}), 0);
      chk("rst_fault", int'(fault), 0);
      #1 rst = 1'b0;
      #1 chk("idle_no_req", int'(bus.imem_req), 0);
      @(negedge clk);
      chk("first_req", int'(bus.imem_req), 1);
      chk("first_addr", int'(bus.imem_addr), int'(PC_RST));

      // Back-to-back fetches from 000, 001, 002; then flags set and cleared by all-zero word
      issue(ALU_W, 0, 4'($urandom));
      issue(ALU_W ^ 19'h00101, 0, 4'($urandom));
      issue(ALU_W, 0, 4'b1100);
      issue(19'd0, 0, 4'b1111);

      // Branch at 0x010: taken with Z=1, not taken with Z=0
      issue(ALU_W, 0, 4'b1000);
      issue(jmp_w(12'h010), 0, 4'($urandom));
      issue({3'b101, 2'b00, 6'd0, 8'h05}, 0, 4'($urandom));
      issue(ALU_W, 0, 4'b0000);
      issue(jmp_w(12'h010), 0, 4'($urandom));
      issue({3'b101, 2'b00, 6'd0, 8'h05}, 0, 4'($urandom));

      // Call 0x200 from 0x030, return to 0x031
      issue(jmp_w(12'h030), 1, 4'($urandom));
      issue(call_w(12'h200), 0, 4'($urandom));
      issue(RET_W, 2, 4'($urandom));

      // LDM with 3 wait cycles, STM, shift
      issue({3'b100, 1'b0, 1'b0, 14'h0123}, 3, 4'($urandom));
      issue({3'b100, 1'b0, 1'b1, 14'h2A11}, 1, 4'($urandom));
      issue({3'b110, 16'h1F0F}, 0, 4'b0011);

      for (int i = 0; i < 300; i++)
         issue(gen_word(), $urandom_range(0, 3), 4'($urandom));

      repeat (10) @(negedge clk);
      chk("sb_drain", sb.size(), 0);

      // Calls beyond the stack depth
      do_reset();
      for (int i = 0; i < DEPTH; i++)
         issue(call_w(12'h100 + 12'(i * 16)), 0, 4'($urandom));
      issue(call_w(12'h700), 0, 4'($urandom));
`ifdef CALLSTACK_GUARD_EN
      @(negedge clk);
      chk("guard_fault", int'(fault), 1);
      for (int i = 0; i < 4; i++) begin
         chk("halt_no_req", int'(bus.imem_req | reg_we | dmem_re | dmem_we | retired), 0);
         @(negedge clk);
      end
      chk("halt_pc_hold", int'(pc), int'(m_pc));
`else
      issue(RET_W, 0, 4'($urandom));
      issue(RET_W, 0, 4'($urandom));
      issue(ALU_W, 0, 4'($urandom));
      @(negedge clk);
      chk("noguard_fault", int'(fault), 0);
`endif

      // Asynchronous reset while an LDM is in MEM
      do_reset();
      issue({3'b100, 1'b0, 1'b0, 14'h0042}, 0, 4'($urandom));
      @(negedge clk);
      chk("mem_dmem_re", int'(dmem_re), 1);
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_dmem_re", int'(dmem_re), 0);
      chk("rst_mid_pc", int'(pc), int'(PC_RST));
      chk("rst_mid_strobes", int'(reg_we | retired | dmem_we), 0);
      sb.delete();
      model_reset();
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the 8-bit, 19-bit-instruction processor datapath: register file, ALU, shifter, data memory and condition flags. It fetches instructions over a req/ack handshake and holds the program counter, the instruction register, the Z/C flags and the call/return stack. Each opcode is stepped through fetch/decode/execute/memory/writeback states, and the block drives every datapath strobe.

## Interface
- STACK_DEPTH, 8, call-stack entries (power of 2, ≥2)
- PC_RESET, 12'h000, program counter value after reset
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- imem_req  out  1  instruction fetch request
- imem_addr  out  12  fetch address (= pc), stable while imem_req=1
- imem_ack  in  1  fetch complete; imem_data valid in the same cycle
- imem_data  in  19  instruction word
- ir  out  19  latched instruction, drives datapath field decode
- pc  out  12  current program counter
- reg_we  out  1  register-file write strobe (1-cycle pulse)
- ra2_sel  out  1  1: read port 2 addressed by ir[13:11] (store)
- wb_sel  out  2  writeback source: 00 ALU, 01 data memory, 10 shifter
- dmem_re / dmem_we  out  1 each  data-memory read enable / write pulse
- alu_cout, alu_zero  in  1 each  ALU carry/zero, valid in EXEC
- sh_cout, sh_zero  in  1 each  shifter carry/zero, valid in EXEC
- flag_z, flag_c  out  1 each  committed flags
- retired  out  1  1-cycle pulse when an instruction completes
- fault  out  1  sticky stack fault (see Configuration)

## Operation
- Opcode decode (ir[18:16]): 0xx ALU; 100 memory (ir[14]=0 LDM, 1 STM); 101 branch; 110 shift; 111 jump/call/return.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT. Reset enters IDLE. IDLE→FETCH unconditionally.
- FETCH: imem_req=1. On the edge with imem_ack=1: ir←imem_data, pc←pc+1 (12-bit wrap), →DECODE. Without ack the block stays in FETCH and imem_addr holds.
- DECODE:
  - ALU and shift go to EXEC.
  - Memory goes to MEM.
  - Branch: condition ir[15:14] is 00 Z, 01 !Z, 10 C, 11 !C, evaluated on the committed flags. If taken, pc←pc+{4'b0,ir[7:0]} (unsigned, wraps). Retire, →FETCH.
  - 111 with ir[15]=0: pc←ir[11:0]. If ir[14]=1, first push the current pc (return address). Retire, →FETCH.
  - 111 with ir[15]=1: pc←top of stack and pop. Retire, →FETCH.
- EXEC: reg_we=1.
  - wb_sel=00 for ALU; Z/C←alu_zero/alu_cout.
  - wb_sel=10 for shift; Z/C←sh_zero/sh_cout.
  - Retire, →FETCH.
- All-zero instruction word: no register write, Z=C=0, retire.
- MEM, LDM: dmem_re=1, →WB.
- MEM, STM: ra2_sel=1, dmem_we=1, retire, →FETCH.
- WB: wb_sel=01, reg_we=1, retire, →FETCH. Memory ops leave the flags unchanged.
- Call/return in the same DECODE is impossible. Push and pop are never simultaneous.

## Timing
- All outputs are registered or decoded from registered state only; there is no combinational path from imem_ack to outputs other than the FETCH exit.
- Reset values: state=IDLE, pc=PC_RESET, ir=0, sp=0, flags=0, fault=0; imem_req, reg_we, dmem_re, dmem_we, retired, ra2_sel=0; wb_sel=00.
- Latency, with ack in the first FETCH cycle:
  - ALU/shift/STM: 3 cycles.
  - LDM: 4 cycles.
  - Branch/jump/call/return: 2 cycles.
  - Each wait cycle on imem_ack adds 1.
- retired is asserted in the final cycle of each instruction.
- The next fetch address appears in the cycle after retired.
- Reset mid-operation: takes effect immediately. Strobes drop asynchronously, no partial write completes, and the stack contents are discarded (sp=0).

## Configuration
- Macro: CALLSTACK_GUARD_EN.
- Defined:
  - A call with sp=STACK_DEPTH or a return with sp=0 sets fault=1 and enters HALT.
  - In HALT, pc and sp are unchanged, all strobes are 0, and imem_req=0.
  - Only rst exits HALT.
- Undefined:
  - sp wraps modulo STACK_DEPTH; an overflow overwrites the oldest entry, and an underflow returns the wrapped entry.
  - fault is tied 0 and HALT is unreachable.

## Test plan
- Reset release with imem_ack held 1: imem_addr sequence is 000, 001, 002. The first imem_req comes one cycle after IDLE.
- ALU op with alu_zero=1, alu_cout=1 → reg_we pulse with wb_sel=00 in EXEC; flag_z=flag_c=1 after that edge. A following all-zero instruction clears both flags.
- Branch at pc 0x010 with cond 00, offset 0x05 and Z=1 → next imem_addr 0x016. With Z=0 → 0x011.
- Call 0x200 at pc 0x030, then return → return fetches from 0x031.
- Calls beyond STACK_DEPTH:
  - With the guard defined, the 9th call (depth 8) → fault=1, HALT, imem_req stays 0.
  - Without the guard, the call proceeds and fault stays 0.
- LDM with imem_ack delayed 3 cycles → dmem_re in MEM, then reg_we with wb_sel=01 one cycle later; retired 7 cycles after FETCH entry. Asserting rst during MEM → dmem_re drops immediately and pc=PC_RESET.
